pifo_pkt_buffer: RTL and testbench

// - Packet-cell buffer for the PIFO scheduler: stores one flit per cell ({tlast,tkeep,tdata}, tuser, tpifo).
// - Successor to the fixed-size BRAM wrapper: depth and widths are parametrised, and an internal free list allocates write addresses.
// - Adds valid/ready on the write side, tvalid on the read side, and address release on read.
// - Sits between the ingress datapath (writer) and the PIFO dequeue logic (reader, which holds cell addresses).

---
 rtl/pifo_pkt_buf_pkg.sv | 32 +++
 rtl/pifo_pkt_buf_free_list.sv | 65 ++++++
 rtl/pifo_pkt_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_pifo_pkt_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkt_buf_pkg.sv
// ---------------------------------------------------------------------------
// pifo_pkt_buf_pkg
// Shared types and constants for the PIFO packet-cell buffer.
//   state_t : buffer FSM states (INIT builds the free list, RUN serves traffic)
//   cell_t  : one stored flit {tlast, tkeep, tdata, tuser, tpifo} at the
//             default widths (the top re-declares the same layout using its
//             own parameters)
//   STAT_W  : width of the optional statistics counters
// ---------------------------------------------------------------------------
package pifo_pkt_buf_pkg;

    localparam int STAT_W      = 32;

    localparam int DEF_DATA_W  = 256;
    localparam int DEF_TUSER_W = 128;
    localparam int DEF_PIFO_W  = 32;
    localparam int DEF_DEPTH   = 4096;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                    tlast;
        logic [DEF_DATA_W/8-1:0] tkeep;
        logic [DEF_DATA_W-1:0]   tdata;
        logic [DEF_TUSER_W-1:0]  tuser;
        logic [DEF_PIFO_W-1:0]   tpifo;
    } cell_t;

endpackage

// File: rtl/pifo_pkt_buf_free_list.sv
// ---------------------------------------------------------------------------
// pifo_pkt_buf_free_list
// DEPTH x ADDR_W FIFO of free cell addresses.
//   clk, rstn    : clock, synchronous active-low reset (pointers/count cleared,
//                  storage not cleared)
//   i_push       : push i_push_addr; dropped (o_ovf pulses next cycle) if full
//   i_push_addr  : address being returned
//   i_pop        : pop the head; ignored when empty
//   o_head       : current head address (combinational)
//   o_count      : entries held, 0..DEPTH
//   o_ovf        : 1-cycle pulse after a push was dropped
// Push and pop in the same cycle both take effect; the count is unchanged.
// ---------------------------------------------------------------------------
module pifo_pkt_buf_free_list #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head,
    output logic [ADDR_W:0]   o_count,
    output logic              o_ovf
);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    // Pointers are ADDR_W bits and wrap naturally mod DEPTH (power of 2).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (ADDR_W+1)'(w_push_ok) - (ADDR_W+1)'(w_pop_ok);
            r_ovf   <= i_push && w_full;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_addr;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/pifo_pkt_buffer.sv
// ---------------------------------------------------------------------------
// pifo_pkt_buffer
// Packet-cell buffer for the PIFO scheduler. Each cell holds one flit
// {tlast, tkeep, tdata, tuser, tpifo}. Write addresses come from an internal
// free list; the reader supplies cell addresses and may return them on read.
//
// Ports
//   clk, rstn          : clock, synchronous active-low reset
//   s_axis_*           : write flit; s_axis_tready = RUN && free cells
//   s_axis_wr_addr     : cell taking the write this cycle (valid with tready)
//   rd_en/rd_addr      : read request, data at +1 (OUTPUT_SYNC=0) or +2 cycles
//   rd_free            : with rd_en, return rd_addr to the free list
//   m_axis_*           : read data, m_axis_tvalid marks each returned read
//   free_cnt           : free cells, 0..DEPTH
//   init_done          : free list built, block in RUN
//   err_free_ovf       : 1-cycle pulse, a free was dropped (list full)
//   dbg_state          : current FSM state
//   stat_*_cnt         : only with PIFO_PKT_BUF_STATS_EN defined; saturating
//                        counts of accepted writes, issued reads, stall cycles
//
// Handshake: a write transfers on any rising edge where s_axis_tvalid and
// s_axis_tready are both 1; the writer must keep the flit stable until then.
// The read side has no backpressure: every issued read returns exactly once.
// ---------------------------------------------------------------------------
module pifo_pkt_buffer
    import pifo_pkt_buf_pkg::*;
#(
    parameter int DATA_W      = 256,
    parameter int TUSER_W     = 128,
    parameter int PIFO_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int OUTPUT_SYNC = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic [TUSER_W-1:0]  s_axis_tuser,
    input  logic [PIFO_W-1:0]   s_axis_tpifo,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [ADDR_W-1:0]   s_axis_wr_addr,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_free,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [TUSER_W-1:0]  m_axis_tuser,
    output logic [PIFO_W-1:0]   m_axis_tpifo,
    output logic                m_axis_tvalid,
    output logic [ADDR_W:0]     free_cnt,
    output logic                init_done,
    output logic                err_free_ovf,
    output logic                dbg_state
`ifdef PIFO_PKT_BUF_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_wr_cnt,
    output logic [STAT_W-1:0]   stat_rd_cnt,
    output logic [STAT_W-1:0]   stat_stall_cnt
`endif
);

    localparam int KEEP_W = DATA_W/8;

    typedef struct packed {
        logic               tlast;
        logic [KEEP_W-1:0]  tkeep;
        logic [DATA_W-1:0]  tdata;
        logic [TUSER_W-1:0] tuser;
        logic [PIFO_W-1:0]  tpifo;
    } mem_cell_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;

    logic              w_run;
    logic [ADDR_W-1:0] w_head;
    logic [ADDR_W:0]   w_cnt;
    logic              w_ovf;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_fl_push;
    logic [ADDR_W-1:0] w_fl_push_addr;
    mem_cell_t         w_wr_cell;
    mem_cell_t         w_out_cell;
    logic              w_out_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    // Last address (DEPTH-1) is pushed in this cycle.
                    if (r_init_cnt == {ADDR_W{1'b1}}) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= INIT;
            endcase
        end
    end

    assign w_run     = (r_state == RUN);
    assign init_done = r_init_done;
    assign dbg_state = r_state;

    // ---------------- free list ----------------
    // A same-cycle free never bypasses into the allocation: tready looks only
    // at the registered count.
    assign s_axis_tready  = w_run && (w_cnt != '0);
    assign s_axis_wr_addr = s_axis_tready ? w_head : '0;
    assign w_wr_fire      = s_axis_tvalid && s_axis_tready;
    assign w_rd_fire      = w_run && rd_en;

    assign w_fl_push      = (r_state == INIT) || (w_rd_fire && rd_free);
    assign w_fl_push_addr = (r_state == INIT) ? r_init_cnt : rd_addr;

    pifo_pkt_buf_free_list #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_free_list (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_fl_push),
        .i_push_addr (w_fl_push_addr),
        .i_pop       (w_wr_fire),
        .o_head      (w_head),
        .o_count     (w_cnt),
        .o_ovf       (w_ovf)
    );

    assign free_cnt     = w_cnt;
    assign err_free_ovf = w_ovf;

    // ---------------- cell storage ----------------
    mem_cell_t r_mem [DEPTH];
    mem_cell_t r_rd_cell;
    logic      r_rd_valid;

    assign w_wr_cell = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep,
                         tdata: s_axis_tdata, tuser: s_axis_tuser,
                         tpifo: s_axis_tpifo};

    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[w_head] <= w_wr_cell;
    end

    // Read-first: a same-edge write to rd_addr is not visible to this read.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_cell  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) r_rd_cell <= r_mem[rd_addr];
        end
    end

    generate
        if (OUTPUT_SYNC != 0) begin : g_out_reg
            mem_cell_t r_out_cell;
            logic      r_out_valid;
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_out_cell  <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_rd_valid;
                    if (r_rd_valid) r_out_cell <= r_rd_cell;
                end
            end
            assign w_out_cell  = r_out_cell;
            assign w_out_valid = r_out_valid;
        end else begin : g_no_out_reg
            assign w_out_cell  = r_rd_cell;
            assign w_out_valid = r_rd_valid;
        end
    endgenerate

    assign m_axis_tdata  = w_out_cell.tdata;
    assign m_axis_tkeep  = w_out_cell.tkeep;
    assign m_axis_tlast  = w_out_cell.tlast;
    assign m_axis_tuser  = w_out_cell.tuser;
    assign m_axis_tpifo  = w_out_cell.tpifo;
    assign m_axis_tvalid = w_out_valid;

`ifdef PIFO_PKT_BUF_STATS_EN
    // ---------------- statistics (saturating) ----------------
    logic [STAT_W-1:0] r_stat_wr;
    logic [STAT_W-1:0] r_stat_rd;
    logic [STAT_W-1:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_wr    <= '0;
            r_stat_rd    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_wr_fire && (r_stat_wr != '1))
                r_stat_wr <= r_stat_wr + 1'b1;
            if (w_rd_fire && (r_stat_rd != '1))
                r_stat_rd <= r_stat_rd + 1'b1;
            if (w_run && s_axis_tvalid && !s_axis_tready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_wr_cnt    = r_stat_wr;
    assign stat_rd_cnt    = r_stat_rd;
    assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_pifo_pkt_buffer.sv
// ---------------------------------------------------------------------------
// tb_pifo_pkt_buffer
// Directed bench for pifo_pkt_buffer with DEPTH=16. Instance a uses
// OUTPUT_SYNC=0, instance b uses OUTPUT_SYNC=1 with its own reset.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_pifo_pkt_buffer;

    localparam int DATA_W  = 32;
    localparam int KEEP_W  = DATA_W/8;
    localparam int TUSER_W = 8;
    localparam int PIFO_W  = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance a signals ----------------
    logic                a_rstn;
    logic [DATA_W-1:0]   a_tdata;
    logic [KEEP_W-1:0]   a_tkeep;
    logic                a_tlast;
    logic [TUSER_W-1:0]  a_tuser;
    logic [PIFO_W-1:0]   a_tpifo;
    logic                a_tvalid;
    logic                a_tready;
    logic [ADDR_W-1:0]   a_wr_addr;
    logic                a_rd_en;
    logic [ADDR_W-1:0]   a_rd_addr;
    logic                a_rd_free;
    logic [DATA_W-1:0]   a_m_tdata;
    logic [KEEP_W-1:0]   a_m_tkeep;
    logic                a_m_tlast;
    logic [TUSER_W-1:0]  a_m_tuser;
    logic [PIFO_W-1:0]   a_m_tpifo;
    logic                a_m_tvalid;
    logic [ADDR_W:0]     a_free_cnt;
    logic                a_init_done;
    logic                a_err;
    logic                a_dbg;

    // ---------------- instance b signals ----------------
    logic                b_rstn;
    logic [DATA_W-1:0]   b_tdata;
    logic                b_tvalid;
    logic                b_tready;
    logic [ADDR_W-1:0]   b_wr_addr;
    logic                b_rd_en;
    logic [ADDR_W-1:0]   b_rd_addr;
    logic [DATA_W-1:0]   b_m_tdata;
    logic [KEEP_W-1:0]   b_m_tkeep;
    logic                b_m_tlast;
    logic [TUSER_W-1:0]  b_m_tuser;
    logic [PIFO_W-1:0]   b_m_tpifo;
    logic                b_m_tvalid;
    logic [ADDR_W:0]     b_free_cnt;
    logic                b_init_done;
    logic                b_err;
    logic                b_dbg;

`ifdef PIFO_PKT_BUF_STATS_EN
    logic [31:0] a_st_wr, a_st_rd, a_st_stall;
    logic [31:0] b_st_wr, b_st_rd, b_st_stall;
`endif

    pifo_pkt_buffer #(
        .DATA_W(DATA_W), .TUSER_W(TUSER_W), .PIFO_W(PIFO_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUTPUT_SYNC(0)
    ) dut_a (
        .clk(clk), .rstn(a_rstn),
        .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tlast(a_tlast),
        .s_axis_tuser(a_tuser), .s_axis_tpifo(a_tpifo), .s_axis_tvalid(a_tvalid),
        .s_axis_tready(a_tready), .s_axis_wr_addr(a_wr_addr),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_free(a_rd_free),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tlast(a_m_tlast),
        .m_axis_tuser(a_m_tuser), .m_axis_tpifo(a_m_tpifo), .m_axis_tvalid(a_m_tvalid),
        .free_cnt(a_free_cnt), .init_done(a_init_done), .err_free_ovf(a_err),
        .dbg_state(a_dbg)
`ifdef PIFO_PKT_BUF_STATS_EN
        , .stat_wr_cnt(a_st_wr), .stat_rd_cnt(a_st_rd), .stat_stall_cnt(a_st_stall)
`endif
    );

    pifo_pkt_buffer #(
        .DATA_W(DATA_W), .TUSER_W(TUSER_W), .PIFO_W(PIFO_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUTPUT_SYNC(1)
    ) dut_b (
        .clk(clk), .rstn(b_rstn),
        .s_axis_tdata(b_tdata), .s_axis_tkeep(4'hF), .s_axis_tlast(1'b1),
        .s_axis_tuser(8'h5A), .s_axis_tpifo(16'h0BEE), .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready), .s_axis_wr_addr(b_wr_addr),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_free(1'b0),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
        .m_axis_tuser(b_m_tuser), .m_axis_tpifo(b_m_tpifo), .m_axis_tvalid(b_m_tvalid),
        .free_cnt(b_free_cnt), .init_done(b_init_done), .err_free_ovf(b_err),
        .dbg_state(b_dbg)
`ifdef PIFO_PKT_BUF_STATS_EN
        , .stat_wr_cnt(b_st_wr), .stat_rd_cnt(b_st_rd), .stat_stall_cnt(b_st_stall)
`endif
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] fd(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h11;
    endfunction

    task automatic drive_flit(input int i);
        a_tdata = fd(i);
        a_tkeep = 4'(i) ^ 4'hF;
        a_tlast = i[0];
        a_tuser = 8'h40 + 8'(i);
        a_tpifo = 16'h1000 + 16'(i);
    endtask

    task automatic check_flit(input string tag, input int i);
        chk({tag, "_tdata"}, 64'(a_m_tdata), 64'(fd(i)));
        chk({tag, "_tkeep"}, 64'(a_m_tkeep), 64'(4'(i) ^ 4'hF));
        chk({tag, "_tlast"}, 64'(a_m_tlast), 64'(i[0]));
        chk({tag, "_tuser"}, 64'(a_m_tuser), 64'(8'h40 + 8'(i)));
        chk({tag, "_tpifo"}, 64'(a_m_tpifo), 64'(16'h1000 + 16'(i)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a_rstn = 1'b0; b_rstn = 1'b0;
        a_tvalid = 1'b0; a_rd_en = 1'b0; a_rd_addr = '0; a_rd_free = 1'b0;
        drive_flit(0);
        b_tvalid = 1'b0; b_tdata = '0; b_rd_en = 1'b0; b_rd_addr = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_tready",    64'(a_tready),    64'd0);
        chk("rst_wr_addr",   64'(a_wr_addr),   64'd0);
        chk("rst_free_cnt",  64'(a_free_cnt),  64'd0);
        chk("rst_init_done", 64'(a_init_done), 64'd0);
        chk("rst_m_tvalid",  64'(a_m_tvalid),  64'd0);
        chk("rst_m_tdata",   64'(a_m_tdata),   64'd0);
        chk("rst_err",       64'(a_err),       64'd0);

        // Init: tready low for 16 cycles, then RUN with 16 free cells
        a_rstn = 1'b1; b_rstn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("init_tready", 64'(a_tready), 64'd0);
            tick();
        end
        chk("init_done",     64'(a_init_done), 64'd1);
        chk("init_free_cnt", 64'(a_free_cnt),  64'd16);
        chk("init_tready1",  64'(a_tready),    64'd1);

        // 16 back-to-back writes allocate 0..15
        a_tvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_flit(i);
            chk("alloc_addr", 64'(a_wr_addr), 64'(i));
            tick();
        end
        chk("full_free_cnt", 64'(a_free_cnt), 64'd0);
        chk("full_tready",   64'(a_tready),   64'd0);
        drive_flit(99);
        tick();
        chk("stall_free_cnt", 64'(a_free_cnt), 64'd0);
        a_tvalid = 1'b0;

        // Read+free cell 5 from full
        a_rd_en = 1'b1; a_rd_addr = 4'd5; a_rd_free = 1'b1;
        tick();
        a_rd_en = 1'b0; a_rd_free = 1'b0;
        chk("rd5_tvalid", 64'(a_m_tvalid), 64'd1);
        check_flit("rd5", 5);
        chk("rd5_free_cnt", 64'(a_free_cnt), 64'd1);
        chk("rd5_wr_addr",  64'(a_wr_addr),  64'd5);
        tick();
        chk("idle_tvalid", 64'(a_m_tvalid), 64'd0);

        // Write cell 5 while reading+freeing cell 9
        drive_flit(50); a_tvalid = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 4'd9; a_rd_free = 1'b1;
        chk("wrrd_wr_addr", 64'(a_wr_addr), 64'd5);
        tick();
        a_tvalid = 1'b0; a_rd_free = 1'b0;
        chk("wrrd_free_cnt", 64'(a_free_cnt), 64'd1);
        chk("wrrd_tvalid",   64'(a_m_tvalid), 64'd1);
        check_flit("wrrd9", 9);
        chk("wrrd_next_addr", 64'(a_wr_addr), 64'd9);

        // Read back the new contents of cell 5
        a_rd_addr = 4'd5;
        tick();
        check_flit("new5", 50);

        // Same-cycle write and read of cell 9: read returns old data
        drive_flit(90); a_tvalid = 1'b1;
        a_rd_addr = 4'd9;
        tick();
        a_tvalid = 1'b0;
        check_flit("rdfirst9", 9);
        chk("rdfirst_free_cnt", 64'(a_free_cnt), 64'd0);
        tick();
        a_rd_en = 1'b0;
        check_flit("new9", 90);

        // Free while empty: no bypass into tready
        drive_flit(77); a_tvalid = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 4'd2; a_rd_free = 1'b1;
        chk("nobypass_tready", 64'(a_tready), 64'd0);
        tick();
        a_tvalid = 1'b0; a_rd_en = 1'b0; a_rd_free = 1'b0;
        chk("nobypass_free_cnt", 64'(a_free_cnt), 64'd1);
        chk("nobypass_wr_addr",  64'(a_wr_addr),  64'd2);

        // Refill free list to 16, then free cell 3 again -> overflow pulse
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 2) begin
                a_rd_en = 1'b1; a_rd_addr = 4'(i); a_rd_free = 1'b1;
                tick();
            end
        end
        a_rd_en = 1'b0; a_rd_free = 1'b0;
        chk("refill_free_cnt", 64'(a_free_cnt), 64'd16);
        chk("refill_wr_addr",  64'(a_wr_addr),  64'd2);
        chk("refill_err",      64'(a_err),      64'd0);
        a_rd_en = 1'b1; a_rd_addr = 4'd3; a_rd_free = 1'b1;
        tick();
        a_rd_en = 1'b0; a_rd_free = 1'b0;
        chk("ovf_pulse",    64'(a_err),      64'd1);
        chk("ovf_free_cnt", 64'(a_free_cnt), 64'd16);
        tick();
        chk("ovf_clear",    64'(a_err),      64'd0);
        chk("ovf_tvalid",   64'(a_m_tvalid), 64'd0);

        // OUTPUT_SYNC=1: latency 2
        b_tdata = 32'hCAFE_0007; b_tvalid = 1'b1;
        chk("b_wr_addr", 64'(b_wr_addr), 64'd0);
        tick();
        b_tvalid = 1'b0;
        b_rd_en = 1'b1; b_rd_addr = 4'd0;
        tick();
        b_rd_en = 1'b0;
        chk("b_lat_t1", 64'(b_m_tvalid), 64'd0);
        tick();
        chk("b_lat_t2",   64'(b_m_tvalid), 64'd1);
        chk("b_lat_data", 64'(b_m_tdata),  64'h0000_0000_CAFE_0007);
        chk("b_lat_user", 64'(b_m_tuser),  64'h5A);
        tick();
        chk("b_lat_t3", 64'(b_m_tvalid), 64'd0);

        // OUTPUT_SYNC=1: reset at t+1 abandons the read
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        b_rstn = 1'b0;
        tick();
        chk("b_rst_tvalid",    64'(b_m_tvalid),  64'd0);
        chk("b_rst_free_cnt",  64'(b_free_cnt),  64'd0);
        chk("b_rst_init_done", 64'(b_init_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
